// File: rtl/ascii_load_sequencer.sv
// Buffers "Load Ascii" bytes from the HPS ioctl stream and replays them 8N1 into the ACIA rxd,
// with per-character and per-line pacing; uart_rxd bypasses the serialiser when selected.
module ascii_load_sequencer #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CHAR_GAP   = 50_000,
  parameter int unsigned LINE_GAP   = 5_000_000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load_from,
  input  logic       baud_rate,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_data,
  output logic       ioctl_wait,
  input  logic       uart_rxd,
  output logic       rxd_out,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned DIV_FAST = CLK_HZ / 9600;
  localparam int unsigned DIV_SLOW = CLK_HZ / 300;
  localparam int unsigned MAX_A    = (DIV_SLOW > LINE_GAP) ? DIV_SLOW : LINE_GAP;
  localparam int unsigned MAX_CNT  = (MAX_A > CHAR_GAP) ? MAX_A : CHAR_GAP;
  localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W   = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, div_q, div_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                cr_q, cr_d, tx_q, tx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic                dl_q, prev_cr_q, prev_cr_d, overrun_q, overrun_d;
  logic                wait_q, wait_d, busy_q, busy_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic                dl_rise, wr_req, prev_eff, drop_lf, full, wr_en, pop;
  logic [7:0]          wr_byte, head;

  assign rxd_out    = load_from ? uart_rxd : tx_q;
  assign ioctl_wait = wait_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign head       = mem_q[rd_ptr_q];

  // Ingest path: CRLF collapse, LF->CR translation, overrun tracking
  always_comb begin
    dl_rise   = ioctl_download & ~dl_q;
    wr_req    = ioctl_download & ioctl_wr & ~load_from;
    prev_eff  = dl_rise ? 1'b0 : prev_cr_q;
    drop_lf   = (ioctl_data == 8'h0A) & prev_eff;
    wr_byte   = (ioctl_data == 8'h0A) ? 8'h0D : ioctl_data;
    full      = (count_q == FCNT_W'(FIFO_DEPTH));
    wr_en     = wr_req & ~drop_lf & ~full;
    prev_cr_d = prev_eff;
    overrun_d = dl_rise ? 1'b0 : overrun_q;
    if (wr_req) begin
      prev_cr_d = (ioctl_data == 8'h0D);
      if (!drop_lf && full) overrun_d = 1'b1;
    end
  end

  // Serialiser next-state and line value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cr_d    = cr_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          cr_d    = (head == 8'h0D);
          div_d   = baud_rate ? CNT_W'(DIV_SLOW) : CNT_W'(DIV_FAST);
          cnt_d   = div_d - CNT_W'(1);
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q - CNT_W'(1);
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q - CNT_W'(1);
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = cr_q ? CNT_W'(LINE_GAP - 1) : CNT_W'(CHAR_GAP - 1);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    if (load_from) begin
      state_d = S_IDLE;
      tx_d    = 1'b1;
      pop     = 1'b0;
    end
  end

  // FIFO bookkeeping; selecting UART flushes the buffer
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + FCNT_W'(wr_en) - FCNT_W'(pop);
    if (load_from) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    wait_d = ~load_from & (count_d >= FCNT_W'(FIFO_DEPTH - 2));
    busy_d = (state_d != S_IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cr_q      <= 1'b0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dl_q      <= 1'b0;
      prev_cr_q <= 1'b0;
      overrun_q <= 1'b0;
      wait_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cr_q      <= cr_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dl_q      <= ioctl_download;
      prev_cr_q <= prev_cr_d;
      overrun_q <= overrun_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_byte;
  end

endmodule

// File: tb/tb_ascii_load_sequencer.sv
// Scoreboard bench: stimulus pushes expected frames, a UART monitor decodes rxd_out and compares.
module tb_ascii_load_sequencer;

  localparam int unsigned DF = 10;
  localparam int unsigned DS = 320;
  localparam int unsigned CG = 20;
  localparam int unsigned LG = 60;

  logic       clk_sys = 1'b0;
  logic       reset, load_from, baud_rate, ioctl_download, ioctl_wr, uart_rxd;
  logic [7:0] ioctl_data;
  logic       ioctl_wait, rxd_out, busy, overrun;

  ascii_load_sequencer #(
    .CLK_HZ(96_000), .FIFO_DEPTH(16), .CHAR_GAP(CG), .LINE_GAP(LG)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .load_from(load_from), .baud_rate(baud_rate),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait), .uart_rxd(uart_rxd), .rxd_out(rxd_out), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc = cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         gap;
    bit         chk;
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b1;
  int    last_start = 0;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input int div, input int gap, input bit chk);
    item_t it;
    it.data = d; it.div = div; it.gap = gap; it.chk = chk;
    exp_q.push_back(it);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_data = d;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  // Wait for busy to drop; compare start-edge-to-idle time
  task automatic wait_idle(input string nm, input int dur);
    int n = 0;
    while (busy && n < 100000) begin
      @(negedge clk_sys);
      n++;
    end
    check({nm, "_timeout"}, int'(busy), 0);
    check(nm, cyc - last_start, dur);
  endtask

  // Monitor: decode 8N1 frames on rxd_out and compare with the scoreboard
  initial begin
    logic       prev = 1'b1;
    logic [7:0] b;
    logic       fr;
    item_t      it, pit;
    bit         have_prev = 1'b0;
    int         t0;
    forever begin
      @(negedge clk_sys);
      if (mon_en && prev && !rxd_out) begin
        t0 = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          it = exp_q.pop_front();
          if (it.chk && have_prev) check("frame_spacing", t0 - last_start, 10 * pit.div + pit.gap + 1);
          last_start = t0;
          fr = 1'b1;
          b  = '0;
          for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? it.div / 2 : it.div) @(negedge clk_sys);
            if (k == 0)      fr = fr & ~rxd_out;
            else if (k == 9) fr = fr & rxd_out;
            else             b[k-1] = rxd_out;
          end
          check("frame_data", int'(b), int'(it.data));
          check("frame_bits", int'(fr), 1);
          pit = it;
          have_prev = 1'b1;
        end
      end
      prev = rxd_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] d;
    reset = 1'b1; load_from = 1'b0; baud_rate = 1'b0; ioctl_download = 1'b0;
    ioctl_wr = 1'b0; ioctl_data = '0; uart_rxd = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_rxd", int'(rxd_out), 1);
    check("rst_wait", int'(ioctl_wait), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);

    // Single 'A' at 9600
    push(8'h41, DF, CG, 1'b0);
    wr_byte(8'h41);
    wait_idle("t1_busy_fall", 10 * DF + CG);

    // CR LF LF -> CR CR with line gaps
    push(8'h0D, DF, LG, 1'b0);
    push(8'h0D, DF, LG, 1'b1);
    wr_byte(8'h0D); wr_byte(8'h0A); wr_byte(8'h0A);
    wait_idle("t2_busy_fall", 10 * DF + LG);

    // Unpaced burst of 20 while the serialiser is busy with a lead byte
    push(8'h55, DF, CG, 1'b0);
    wr_byte(8'h55);
    repeat (3) @(negedge clk_sys);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) push(8'(8'h60 + i), DF, CG, 1'b1);
      wr_byte(8'(8'h60 + i));
      if (i == 12) check("t3_wait_at13", int'(ioctl_wait), 0);
      if (i == 13) check("t3_wait_at14", int'(ioctl_wait), 1);
    end
    check("t3_overrun", int'(overrun), 1);
    wait_idle("t3_busy_fall", 10 * DF + CG);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("t3_overrun_clr", int'(overrun), 0);

    // 100 bytes honouring ioctl_wait
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (ioctl_wait && n < 5000) begin
        @(negedge clk_sys);
        n++;
      end
      if (n >= 5000) check("t4_wait_timeout", 1, 0);
      d = 8'(8'h20 + (i % 90));
      push(d, DF, CG, 1'b0);
      wr_byte(d);
    end
    check("t4_overrun", int'(overrun), 0);
    wait_idle("t4_busy_fall", 10 * DF + CG);

    // UART takeover mid-DATA flushes and idles the serialiser
    mon_en = 1'b0;
    wr_byte(8'h5A); wr_byte(8'h5B);
    repeat (30) @(negedge clk_sys);
    load_from = 1'b1;
    uart_rxd  = 1'b0;
    @(negedge clk_sys);
    check("t5_follow0", int'(rxd_out), 0);
    uart_rxd = 1'b1;
    @(negedge clk_sys);
    check("t5_follow1", int'(rxd_out), 1);
    uart_rxd = 1'b0;
    wr_byte(8'h42);
    check("t5_follow2", int'(rxd_out), 0);
    check("t5_wait", int'(ioctl_wait), 0);
    check("t5_busy", int'(busy), 0);
    uart_rxd = 1'b1;
    @(negedge clk_sys);
    load_from = 1'b0;
    @(negedge clk_sys);
    check("t5_tx_idle", int'(rxd_out), 1);
    check("t5_busy_after", int'(busy), 0);
    mon_en = 1'b1;
    repeat (300) @(negedge clk_sys);
    check("t5_still_idle", int'(busy), 0);

    // Baud change during byte 1 applies to byte 2 only
    push(8'h31, DF, CG, 1'b0);
    push(8'h32, DS, CG, 1'b1);
    wr_byte(8'h31); wr_byte(8'h32);
    repeat (20) @(negedge clk_sys);
    baud_rate = 1'b1;
    wait_idle("t6_busy_fall", 10 * DS + CG);
    baud_rate = 1'b0;

    // Reset mid-byte abandons the frame
    mon_en = 1'b0;
    wr_byte(8'h77);
    repeat (25) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check("t7_rst_rxd", int'(rxd_out), 1);
    check("t7_rst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    mon_en = 1'b1;
    repeat (200) @(negedge clk_sys);
    check("t7_idle", int'(busy), 0);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
